// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg: framing bytes, one-hot FSM states and helpers for the UART-to-APB command sequencer.
// UART_CMD_CHECKSUM_EN adds the S_CSUM state for the trailing checksum byte.
package uart_apb_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h57;
    localparam logic [7:0] CMD_RD    = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [7:0] {
        S_SYNC   = 8'b0000_0001,
        S_CMD    = 8'b0000_0010,
        S_ADDR   = 8'b0000_0100,
        S_DATA   = 8'b0000_1000,
        S_SETUP  = 8'b0001_0000,
        S_ACCESS = 8'b0010_0000,
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM   = 8'b1000_0000,
`endif
        S_RESP   = 8'b0100_0000
    } state_t;

    // Mid-frame states: RX is accepted and the inter-byte timeout runs.
    function automatic logic is_mid(state_t s);
`ifdef UART_CMD_CHECKSUM_EN
        return s inside {S_CMD, S_ADDR, S_DATA, S_CSUM};
`else
        return s inside {S_CMD, S_ADDR, S_DATA};
`endif
    endfunction

endpackage

// File: rtl/uart_rsp_shifter.sv
// uart_rsp_shifter: sends a status byte plus an optional 32-bit word (MSB first) over a
// valid/ready byte stream; done pulses in the cycle the last byte is accepted.
module uart_rsp_shifter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [7:0]  status,
    input  logic [31:0] word,
    input  logic [2:0]  len,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [7:0]  o_tdata,
    output logic        done
);

    logic [31:0] word_q, word_d;
    logic [2:0]  left_q, left_d;
    logic        vld_q, vld_d;
    logic [7:0]  dat_q, dat_d;
    logic        acc;

    assign acc      = vld_q & o_tready;
    assign done     = acc && left_q == 3'd0;
    assign o_tvalid = vld_q;
    assign o_tdata  = dat_q;

    always_comb begin
        word_d = load ? word : acc ? {word_q[23:0], 8'h00} : word_q;
        left_d = load ? 3'(len - 3'd1) : (acc && !done) ? 3'(left_q - 3'd1) : left_q;
        vld_d  = load ? 1'b1 : done ? 1'b0 : vld_q;
        dat_d  = load ? status : (acc && !done) ? word_q[31:24] : dat_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_q <= '0;
            left_q <= '0;
            vld_q  <= 1'b0;
            dat_q  <= '0;
        end else begin
            word_q <= word_d;
            left_q <= left_d;
            vld_q  <= vld_d;
            dat_q  <= dat_d;
        end
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: parses A5-framed read/write commands from a UART RX byte stream, runs one
// APB transfer and returns ACK/NAK (+ read data). UART_CMD_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_cmd_sequencer
    import uart_apb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 500000,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_tvalid,
    output logic          i_tready,
    input  logic [7:0]    i_tdata,
    output logic          o_tvalid,
    input  logic          o_tready,
    output logic [7:0]    o_tdata,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [31:0]   pwdata,
    input  logic [31:0]   prdata,
    input  logic          pready,
    input  logic          pslverr
);

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_t S_LAST = S_CSUM;
    logic [7:0] csum_q, csum_d;
`else
    localparam state_t S_LAST = S_SETUP;
`endif

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    logic          i_tready_q, i_tready_d;
    logic          acc, load, done;
    logic [7:0]    ld_status;
    logic [2:0]    ld_len;

    assign acc      = i_tvalid & i_tready_q;
    assign i_tready = i_tready_q;
    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        load      = 1'b0;
        ld_status = RSP_ACK;
        ld_len    = 3'd1;
        unique case (state_q)
            S_SYNC: state_d = (acc && i_tdata == SYNC_BYTE) ? S_CMD : S_SYNC;
            S_CMD: if (acc) begin
                state_d  = (i_tdata == CMD_WR || i_tdata == CMD_RD) ? S_ADDR : S_SYNC;
                pwrite_d = (state_d == S_ADDR) ? i_tdata == CMD_WR : pwrite_q;
            end
            S_ADDR: if (acc) begin
                paddr_d = {paddr_q[AW-9:0], i_tdata};
                cnt_d   = cnt_q + 2'd1;
                state_d = cnt_q != 2'd3 ? S_ADDR : pwrite_q ? S_DATA : S_LAST;
            end
            S_DATA: if (acc) begin
                pwdata_d = {pwdata_q[23:0], i_tdata};
                cnt_d    = cnt_q + 2'd1;
                state_d  = cnt_q == 2'd3 ? S_LAST : S_DATA;
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM: if (acc) begin
                state_d   = i_tdata == csum_q ? S_SETUP : S_RESP;
                load      = i_tdata != csum_q;
                ld_status = RSP_NAK;
            end
`endif
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: if (pready) begin
                state_d   = S_RESP;
                load      = 1'b1;
                ld_status = pslverr ? RSP_NAK : RSP_ACK;
                ld_len    = pwrite_q ? 3'd1 : 3'd5;
            end
            S_RESP: state_d = done ? S_SYNC : S_RESP;
            default: state_d = S_SYNC;
        endcase
        // An accepted byte always clears the count, so a byte landing on the expiry cycle wins.
        tmo_d = (is_mid(state_q) && !acc) ? tmo_q + 32'd1 : 32'd0;
        if (TIMEOUT != 0 && is_mid(state_q) && !acc && tmo_q == TIMEOUT - 1)
            state_d = S_SYNC;
        if (state_d != state_q) begin
            cnt_d = 2'd0;
            tmo_d = 32'd0;
        end
`ifdef UART_CMD_CHECKSUM_EN
        csum_d = state_q == S_SYNC ? 8'h00 : acc ? csum_q ^ i_tdata : csum_q;
`endif
        i_tready_d = state_d == S_SYNC || is_mid(state_d);
        psel_d     = state_d == S_SETUP || state_d == S_ACCESS;
        penable_d  = state_d == S_ACCESS;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_SYNC;
            cnt_q      <= '0;
            tmo_q      <= '0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            i_tready_q <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            i_tready_q <= i_tready_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    uart_rsp_shifter u_rsp (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .status   (ld_status),
        .word     (prdata),
        .len      (ld_len),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .o_tdata  (o_tdata),
        .done     (done)
    );

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed frames with hand-computed APB and response expectations.
module tb_uart_cmd_sequencer;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        i_tvalid = 1'b0, i_tready;
    logic [7:0]  i_tdata = 8'h00;
    logic        o_tvalid, o_tready = 1'b0;
    logic [7:0]  o_tdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = 32'h0;
    logic        pready = 1'b0, pslverr = 1'b0;

    int errors = 0, checks = 0;
    int lat = 0;
    bit tog = 1'b0;
    byte unsigned rsp[$];
    int apb_n = 0, psel_cyc = 0, pen_cyc = 0, pen_run = 0;
    logic [31:0] last_addr = 0, last_wdata = 0;
    logic last_write = 0;
    int rb, ab, sb, eb;

    always #5 clk = ~clk;

    uart_cmd_sequencer #(.TIMEOUT(100), .AW(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tdata(i_tdata),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tdata(o_tdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Response sink and APB slave: values set here hold until the next posedge.
    always @(negedge clk) begin
        o_tready = tog ? !o_tready : 1'b1;
        if (o_tvalid && o_tready) rsp.push_back(o_tdata);
        if (psel) psel_cyc++;
        if (penable) pen_cyc++;
        pen_run = penable ? pen_run + 1 : 0;
        pready = penable && pen_run > lat;
        if (pready) begin
            apb_n++;
            last_addr = paddr;
            last_wdata = pwdata;
            last_write = pwrite;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rsp_at(input int i);
        return (rb + i < rsp.size()) ? rsp[rb + i] : 8'hEE;
    endfunction

    task automatic mark();
        rb = rsp.size(); ab = apb_n; sb = psel_cyc; eb = pen_cyc;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        i_tdata = b;
        i_tvalid = 1'b1;
        while (!i_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready", i_tready, 1'b1);
        @(negedge clk);
        i_tvalid = 1'b0;
    endtask

    task automatic send_frame(input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [7:0] cs;
        cs = wr ? 8'h57 : 8'h52;
        send(8'hA5);
        send(cs);
        for (int i = 3; i >= 0; i--) begin
            send(a[i*8 +: 8]);
            cs ^= a[i*8 +: 8];
        end
        if (wr) for (int i = 3; i >= 0; i--) begin
            send(d[i*8 +: 8]);
            cs ^= d[i*8 +: 8];
        end
`ifdef UART_CMD_CHECKSUM_EN
        send(cs);
`endif
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp.size() < rb + n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        check("rsp_len", rsp.size() - rb, n);
    endtask

    task automatic check_read(input logic [31:0] a, input logic [31:0] d);
        check("rd_apb_n", apb_n - ab, 1);
        check("rd_addr", last_addr, a);
        check("rd_write", last_write, 1'b0);
        check("rd_status", rsp_at(0), 8'h06);
        for (int i = 0; i < 4; i++) check("rd_byte", rsp_at(i + 1), d[(3-i)*8 +: 8]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_i_tready", i_tready, 1'b0);
        check("rst_o_tvalid", o_tvalid, 1'b0);
        check("rst_o_tdata", o_tdata, 8'h00);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_i_tready", i_tready, 1'b1);

        // Write, zero-wait slave
        mark();
        send_frame(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
        wait_rsp(1);
        check("wr_apb_n", apb_n - ab, 1);
        check("wr_addr", last_addr, 32'h0000_1004);
        check("wr_data", last_wdata, 32'hDEAD_BEEF);
        check("wr_write", last_write, 1'b1);
        check("wr_psel_cyc", psel_cyc - sb, 2);
        check("wr_status", rsp_at(0), 8'h06);

        // Read with 5 wait states and a stalling response sink
        lat = 5; prdata = 32'h1234_5678; tog = 1'b1;
        mark();
        send_frame(1'b0, 32'h0000_2000, 32'h0);
        wait_rsp(5);
        check_read(32'h0000_2000, 32'h1234_5678);
        check("rd_pen_cyc", pen_cyc - eb, 6);
        check("rd_psel_cyc", psel_cyc - sb, 7);
        lat = 0; tog = 1'b0;

        // Garbage and a bad command byte are dropped silently
        prdata = 32'hCAFE_F00D;
        mark();
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h33);
        send_frame(1'b0, 32'h0000_3000, 32'h0);
        wait_rsp(5);
        check_read(32'h0000_3000, 32'hCAFE_F00D);

        // Partial frame abandoned by the inter-byte timeout
        prdata = 32'h0BAD_BEEF;
        mark();
        send(8'hA5); send(8'h52); send(8'h00);
        repeat (100) @(negedge clk);
        send_frame(1'b0, 32'h0000_4000, 32'h0);
        wait_rsp(5);
        check_read(32'h0000_4000, 32'h0BAD_BEEF);

        // Byte arriving on the expiry cycle is taken and the frame survives
        prdata = 32'h1122_3344;
        mark();
        send(8'hA5); send(8'h52); send(8'h00); send(8'h00);
        repeat (99) @(negedge clk);
        send(8'h50); send(8'h00);
`ifdef UART_CMD_CHECKSUM_EN
        send(8'h02);
`endif
        wait_rsp(5);
        check_read(32'h0000_5000, 32'h1122_3344);

        // Slave error on a write, then a clean write
        pslverr = 1'b1;
        mark();
        send_frame(1'b1, 32'h0000_6000, 32'h0000_0001);
        wait_rsp(1);
        check("err_status", rsp_at(0), 8'h15);
        check("err_apb_n", apb_n - ab, 1);
        pslverr = 1'b0;
        mark();
        send_frame(1'b1, 32'h0000_6004, 32'h0000_0002);
        wait_rsp(1);
        check("after_err_status", rsp_at(0), 8'h06);
        check("after_err_addr", last_addr, 32'h0000_6004);
        check("after_err_data", last_wdata, 32'h0000_0002);

`ifdef UART_CMD_CHECKSUM_EN
        // Wrong checksum (correct is 0x61): NAK and no APB access
        mark();
        send(8'hA5); send(8'h57);
        send(8'h00); send(8'h00); send(8'h10); send(8'h04);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        send(8'h00);
        wait_rsp(1);
        check("csum_status", rsp_at(0), 8'h15);
        check("csum_psel_cyc", psel_cyc - sb, 0);
        check("csum_apb_n", apb_n - ab, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
